imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
- Writer for the instruction memory that the fetch unit reads through `addra = PC[15:2]`.
- Receives a program image over a UART line (8N1), assembles bytes into 32-bit words, and issues single-cycle writes to the instruction memory write port at consecutive word addresses.
- Holds the CPU stalled (`cpu_hold`) while loading, and flags completion and framing errors.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (≥4); 100 MHz / 115200 baud.
- ADDR_W, 14, width of the instruction memory word address (matches PC[15:2]).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  level; 1 = loader mode requested.
- uart_rx  in  1  serial input; idle high; asynchronous to clock.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  1 = CPU must keep PC reset and stalled.
- done  out  1  image fully written.
- frame_err  out  1  sticky; a stop bit was sampled low.
- word_cnt  out  16  words written in the current load.

Behaviour:
- Reset (reset=0, asynchronous):
  - imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, frame_err=0, word_cnt=0.
  - RX FSM goes to R_IDLE; load FSM goes to L_IDLE.
  - Synchronizer flops are set to 1.
- uart_rx input path: two-flop synchronizer; all logic uses the synchronized value only.
- RX FSM:
  - R_IDLE: on a synchronized falling edge, go to R_START.
  - R_START: wait CLKS_PER_BIT/2 cycles, then resample.
    - Low → go to R_DATA.
    - High → glitch; return to R_IDLE.
  - R_DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits.
  - R_STOP: sample after CLKS_PER_BIT cycles.
    - High → internal byte_valid pulses for 1 cycle with the byte.
    - Low → frame_err<=1 and the byte is discarded.
  - Return to R_IDLE in both cases.
- The RX FSM runs regardless of load_en. Bytes that arrive while the load FSM is not accepting them are dropped.
- Load FSM states: L_IDLE, L_HDR_HI, L_HDR_LO, L_DATA, L_DONE.
  - L_IDLE: cpu_hold=0. When load_en=1: go to L_HDR_HI, set cpu_hold=1, imem_addr=0, word_cnt=0, byte index=0, frame_err=0.
  - L_HDR_HI: next byte becomes N[15:8]; go to L_HDR_LO.
  - L_HDR_LO: next byte becomes N[7:0].
    - N==0 → go to L_DONE.
    - Otherwise → go to L_DATA.
  - L_DATA: bytes are big-endian; 1st byte→[31:24], 2nd→[23:16], 3rd→[15:8], 4th→[7:0].
    - On the 4th byte: imem_wdata takes the full word and imem_we=1 in the following cycle (exactly 1 cycle).
    - On the cycle after the strobe: imem_addr+=1 (wraps modulo 2^ADDR_W) and word_cnt+=1.
    - When word_cnt reaches N: go to L_DONE.
    - imem_addr and imem_wdata stay stable while imem_we=1.
  - L_DONE: done=1, cpu_hold=0, further bytes ignored. When load_en=0: done<=0 and go to L_IDLE.
- Abort: load_en=0 in L_HDR_HI, L_HDR_LO or L_DATA:
  - Go to L_IDLE on the next clock; cpu_hold<=0.
  - Any partial word is discarded and no write is issued.
  - Words already written remain in memory.
- Simultaneous events:
  - byte_valid in the same cycle that load_en falls: the byte is ignored and the abort wins.
  - A framing error during L_DATA does not advance the byte index, so the partial word waits for a valid byte.
- N larger than 2^ADDR_W: writes wrap to address 0; word_cnt keeps counting up to N (16-bit).
- Latency from the last stop-bit sample of the 4th byte to imem_we: 2 clocks (byte_valid, then strobe).

Test Plan:
- Basic load (CLKS_PER_BIT=4):
  - Stimulus: reset low then high; load_en=1; send bytes 00 02 12 34 56 78 DE AD BE EF.
  - Required response: imem_we pulses twice; first write addr=0, data=0x12345678; second write addr=1, data=0xDEADBEEF; then done=1, cpu_hold=0, word_cnt=2.
- Zero-length image:
  - Stimulus: load_en=1; send header 00 00.
  - Required response: no imem_we; done=1 immediately after the 2nd byte; load_en=0 → done=0, FSM back to L_IDLE.
- Framing error:
  - Stimulus: header 00 01; send byte AA with stop bit 0; then send AA BB CC DD.
  - Required response: frame_err=1 (sticky); one write of 0xAABBCCDD at addr 0; done=1.
- Abort mid-word:
  - Stimulus: header 00 04; send 11 22 33 44 55; drop load_en.
  - Required response: exactly one write (0x11223344 at addr 0); cpu_hold=0 next clock; no second write; later bytes ignored.
- Asynchronous reset mid-byte:
  - Stimulus: pull reset low during R_DATA.
  - Required response: all outputs go to 0 without waiting for a clock edge; after release, a fresh load from addr 0 behaves as in the basic load.
- Start-bit glitch and address wrap:
  - Stimulus: drive uart_rx low for 1 cycle; separately, with ADDR_W=2, header 00 05 and 20 bytes.
  - Required response: the glitch produces no byte. The wrap case writes to addresses 0,1,2,3,0, ending with word_cnt=5 and done=1.

Source files
------------

// File: rtl/imem_uart_loader.sv
// UART (8N1) program loader for the instruction memory.
// Receives a 16-bit big-endian word count N followed by N big-endian 32-bit words,
// writes them to consecutive word addresses and holds the CPU while loading.
module imem_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              frame_err,
    output logic [15:0]       word_cnt
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] L_IDLE   = 3'd0;
    localparam logic [2:0] L_HDR_HI = 3'd1;
    localparam logic [2:0] L_HDR_LO = 3'd2;
    localparam logic [2:0] L_DATA   = 3'd3;
    localparam logic [2:0] L_DONE   = 3'd4;

    logic             rx_meta, rx_sync, rx_prev;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    logic             stop_err;

    logic [2:0]       l_state;
    logic [15:0]      n_len;
    logic [1:0]       byte_idx;
    logic [23:0]      word_sr;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver: mid-bit sampling; byte_valid / stop_err are one-cycle pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state   <= R_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_prev && !rx_sync) rx_state <= R_START;
                end
                R_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= R_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_sync) byte_valid <= 1'b1;
                        else         stop_err   <= 1'b1;
                        rx_state <= R_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Load sequencer: header, word assembly, write strobe, then address/count advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            l_state    <= L_IDLE;
            n_len      <= '0;
            byte_idx   <= '0;
            word_sr    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            word_cnt   <= '0;
        end else begin
            if (stop_err) frame_err <= 1'b1;
            case (l_state)
                L_IDLE: begin
                    if (load_en) begin
                        l_state   <= L_HDR_HI;
                        cpu_hold  <= 1'b1;
                        imem_addr <= '0;
                        word_cnt  <= '0;
                        byte_idx  <= '0;
                        frame_err <= 1'b0;
                    end
                end
                L_HDR_HI: begin
                    if (!load_en) begin
                        l_state  <= L_IDLE;
                        cpu_hold <= 1'b0;
                    end else if (byte_valid) begin
                        n_len[15:8] <= rx_shift;
                        l_state     <= L_HDR_LO;
                    end
                end
                L_HDR_LO: begin
                    if (!load_en) begin
                        l_state  <= L_IDLE;
                        cpu_hold <= 1'b0;
                    end else if (byte_valid) begin
                        n_len[7:0] <= rx_shift;
                        if ({n_len[15:8], rx_shift} == 16'd0) begin
                            l_state  <= L_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            l_state <= L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (!load_en) begin
                        // Abort: a pending partial word is simply forgotten.
                        l_state  <= L_IDLE;
                        cpu_hold <= 1'b0;
                        imem_we  <= 1'b0;
                    end else if (imem_we) begin
                        imem_we   <= 1'b0;
                        imem_addr <= imem_addr + ADDR_W'(1);
                        word_cnt  <= word_cnt + 16'd1;
                        if (word_cnt + 16'd1 == n_len) begin
                            l_state  <= L_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
                    end else if (byte_valid) begin
                        if (byte_idx == 2'd3) begin
                            imem_wdata <= {word_sr, rx_shift};
                            imem_we    <= 1'b1;
                        end else begin
                            word_sr <= {word_sr[15:0], rx_shift};
                        end
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                L_DONE: begin
                    if (!load_en) begin
                        done    <= 1'b0;
                        l_state <= L_IDLE;
                    end
                end
                default: begin
                    l_state  <= L_IDLE;
                    cpu_hold <= 1'b0;
                    done     <= 1'b0;
                    imem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader (small bit period, 2-bit word address).
module tb_imem_uart_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          load_en = 1'b0;
    logic          uart_rx = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold, done, frame_err;
    logic [15:0]   word_cnt;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_en    (load_en),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .frame_err  (frame_err),
        .word_cnt   (word_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [15:0]   n;
        int            nbytes;
        int            exp_writes;
        logic          exp_done;
        logic [15:0]   exp_cnt;
        logic [AW-1:0] exp_addr;
    } vec_t;

    wr_t        wq[$];
    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    vec_t       vecs[6];
    int         checks = 0;
    int         errors = 0;

    // Write monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (imem_we) wq.push_back('{addr: imem_addr, data: imem_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic send_all();
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
        repeat (8) @(negedge clock);
    endtask

    // Reference: header gives N; each complete group of 4 following bytes is one
    // big-endian word; word k lands at address k mod 2^AW; at most N words are written.
    task automatic build_model();
        int n, nw, ne;
        exp_q.delete();
        n  = int'({tx_q[0], tx_q[1]});
        nw = (tx_q.size() - 2) / 4;
        ne = (n < nw) ? n : nw;
        for (int k = 0; k < ne; k++)
            exp_q.push_back('{addr: AW'(k),
                              data: {tx_q[2+4*k], tx_q[3+4*k], tx_q[4+4*k], tx_q[5+4*k]}});
    endtask

    task automatic check_writes(input string tag);
        int m;
        chk({tag, " write count"}, wq.size(), exp_q.size());
        m = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), 32'(wq[i].addr), 32'(exp_q[i].addr));
            chk($sformatf("%s data[%0d]", tag, i), wq[i].data, exp_q[i].data);
        end
        wq.delete();
    endtask

    task automatic start_load(input logic [15:0] n, input int nbytes);
        tx_q.delete();
        tx_q.push_back(n[15:8]);
        tx_q.push_back(n[7:0]);
        for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
        load_en = 1'b1;
        repeat (2) @(negedge clock);
        chk("hold while loading", 32'(cpu_hold), 32'd1);
    endtask

    task automatic end_load(input string tag);
        load_en = 1'b0;
        repeat (2) @(negedge clock);
        chk({tag, " done cleared"}, 32'(done), 32'd0);
        chk({tag, " hold cleared"}, 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        int n, nb, ne;
        vecs[0] = '{16'd1, 4,  1, 1'b1, 16'd1, 2'd1};
        vecs[1] = '{16'd2, 11, 2, 1'b1, 16'd2, 2'd2};
        vecs[2] = '{16'd0, 4,  0, 1'b1, 16'd0, 2'd0};
        vecs[3] = '{16'd3, 6,  1, 1'b0, 16'd1, 2'd1};
        vecs[4] = '{16'd5, 20, 5, 1'b1, 16'd5, 2'd1};
        vecs[5] = '{16'd4, 16, 4, 1'b1, 16'd4, 2'd0};

        repeat (3) @(negedge clock);
        chk("reset outputs", {imem_we, cpu_hold, done, frame_err},
            32'd0);
        chk("reset addr/cnt", {imem_addr, word_cnt}, 32'd0);
        chk("reset wdata", imem_wdata, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Basic load with fixed bytes.
        start_load(16'd2, 0);
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_all();
        exp_q.delete();
        exp_q.push_back('{addr: 2'd0, data: 32'h12345678});
        exp_q.push_back('{addr: 2'd1, data: 32'hDEADBEEF});
        check_writes("basic");
        chk("basic done", 32'(done), 32'd1);
        chk("basic hold", 32'(cpu_hold), 32'd0);
        chk("basic cnt", 32'(word_cnt), 32'd2);
        end_load("basic");

        // Table vectors with random payloads.
        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            start_load(vecs[v].n, vecs[v].nbytes);
            send_all();
            build_model();
            chk({tag, " table writes"}, wq.size(), vecs[v].exp_writes);
            check_writes(tag);
            chk({tag, " done"}, 32'(done), 32'(vecs[v].exp_done));
            chk({tag, " hold"}, 32'(cpu_hold), 32'(!vecs[v].exp_done));
            chk({tag, " cnt"}, 32'(word_cnt), 32'(vecs[v].exp_cnt));
            chk({tag, " addr"}, 32'(imem_addr), 32'(vecs[v].exp_addr));
            end_load(tag);
        end

        // Framing error: bad byte is dropped, flag is sticky.
        start_load(16'd1, 0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b0);
        chk("ferr set", 32'(frame_err), 32'd1);
        tx_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        repeat (8) @(negedge clock);
        build_model();
        check_writes("ferr");
        chk("ferr sticky", 32'(frame_err), 32'd1);
        chk("ferr done", 32'(done), 32'd1);
        end_load("ferr");

        // Abort mid-word.
        start_load(16'd4, 5);
        chk("ferr cleared on new load", 32'(frame_err), 32'd0);
        tx_q = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_all();
        load_en = 1'b0;
        @(posedge clock);
        #1;
        chk("abort hold next clock", 32'(cpu_hold), 32'd0);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        repeat (8) @(negedge clock);
        tx_q = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        build_model();
        check_writes("abort");
        chk("abort cnt", 32'(word_cnt), 32'd1);
        chk("abort done", 32'(done), 32'd0);

        // Asynchronous reset in the middle of a data byte.
        start_load(16'd2, 4);
        send_all();
        build_model();
        check_writes("prereset");
        chk("prereset cnt", 32'(word_cnt), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2 reset = 1'b0;
        #1;
        chk("async reset flags", {imem_we, cpu_hold, done, frame_err}, 32'd0);
        chk("async reset addr/cnt", {imem_addr, word_cnt}, 32'd0);
        chk("async reset wdata", imem_wdata, 32'd0);
        @(negedge clock);
        uart_rx = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        start_load(16'd2, 8);
        send_all();
        build_model();
        check_writes("postreset");
        chk("postreset done", 32'(done), 32'd1);
        end_load("postreset");

        // Start-bit glitch must not produce a byte.
        load_en = 1'b1;
        repeat (2) @(negedge clock);
        uart_rx = 1'b0;
        @(negedge clock);
        uart_rx = 1'b1;
        repeat (6 * CPB) @(negedge clock);
        tx_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send_all();
        build_model();
        check_writes("glitch");
        chk("glitch done", 32'(done), 32'd1);
        chk("glitch cnt", 32'(word_cnt), 32'd1);
        end_load("glitch");

        // Random images, possibly truncated.
        for (int r = 0; r < 5; r++) begin
            string tag;
            tag = $sformatf("rand%0d", r);
            n  = $urandom_range(1, 6);
            nb = $urandom_range(0, 4 * n + 3);
            ne = (nb / 4 < n) ? nb / 4 : n;
            start_load(16'(n), nb);
            send_all();
            build_model();
            check_writes(tag);
            chk({tag, " done"}, 32'(done), 32'(nb / 4 >= n));
            chk({tag, " cnt"}, 32'(word_cnt), 32'(ne));
            chk({tag, " addr"}, 32'(imem_addr), 32'(ne % 4));
            end_load(tag);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
